// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// The header feature is enabled by defining UART_TX_ARB_HDR_EN.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_t;

  // MSB value of a header byte, marking it apart from payload.
  localparam logic HDR_MARKER = 1'b1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin selector: first active request after last_grant.
module uart_rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               any,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index
);

  logic             found;
  logic [IDX_W-1:0] cand;

  assign any = |req;

  // Walk from last_grant+1 around the ring; the first hit wins.
  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        onehot[cand]  = 1'b1;
        index         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port among byte streams.
// Define UART_TX_ARB_HDR_EN to prefix each burst with a requester header byte.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int FIFO_WIDTH    = 8,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  output logic                          tx_enable,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int BW    = $clog2(MAX_BURST + 1);
  localparam int SW    = $clog2(STALL_TIMEOUT + 1);

  localparam logic [BW-1:0]    BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0]    STALL_LAST = SW'(STALL_TIMEOUT - 1);
  localparam logic [SW-1:0]    STALL_MAX  = SW'(STALL_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(NUM_REQ - 1);

  arb_state_t state, state_next;

  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      last_grant;
  logic [BW-1:0]         burst_cnt;
  logic [SW-1:0]         stall_cnt;

  logic                  pick_any;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]      pick_index;

  logic                  granted_valid;
  logic                  granted_last;
  logic [FIFO_WIDTH-1:0] granted_data;
  logic                  start;
  logic                  finish;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .onehot     (pick_onehot),
    .index      (pick_index)
  );

  assign granted_valid = req_valid[grant_idx];
  assign granted_last  = req_last[grant_idx];
  assign granted_data  = req_data[int'(grant_idx)*FIFO_WIDTH +: FIFO_WIDTH];
  assign busy          = (state != ST_IDLE);

`ifdef UART_TX_ARB_HDR_EN
  localparam arb_state_t GRANT_STATE = ST_HDR;

  logic [FIFO_WIDTH-1:0] hdr_byte;

  always_comb begin
    hdr_byte                  = '0;
    hdr_byte[FIFO_WIDTH-1]    = HDR_MARKER;
    hdr_byte[IDX_W-1:0]       = grant_idx;
  end
`else
  localparam arb_state_t GRANT_STATE = ST_XFER;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx_enable <= 1'b0;
    end else begin
      state     <= state_next;
      tx_enable <= enable;
    end
  end

  // Write strobe and handshake are combinational so full throttles the same cycle.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    req_ready  = '0;
    data_in    = '0;
    start      = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && pick_any) begin
          start      = 1'b1;
          state_next = GRANT_STATE;
        end
      end
`ifdef UART_TX_ARB_HDR_EN
      ST_HDR: begin
        data_in = hdr_byte;
        wr_en   = !full;
        if (!full) begin
          state_next = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        data_in   = granted_data;
        wr_en     = granted_valid && !full;
        req_ready = wr_en ? grant : '0;
        if (wr_en && (granted_last || burst_cnt == BURST_LAST)) begin
          finish = 1'b1;
        end else if (!granted_valid && stall_cnt == STALL_LAST) begin
          finish = 1'b1;
        end
        if (finish) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Ownership is latched at grant time; last_grant advances when the burst ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      grant_idx  <= '0;
      last_grant <= LAST_INIT;
    end else if (start) begin
      grant      <= pick_onehot;
      grant_idx  <= pick_index;
    end else if (finish) begin
      grant      <= '0;
      last_grant <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else if (start) begin
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else if (state == ST_XFER) begin
      if (wr_en) begin
        burst_cnt <= burst_cnt + BW'(1);
      end
      if (granted_valid) begin
        stall_cnt <= '0;
      end else if (stall_cnt != STALL_MAX) begin
        stall_cnt <= stall_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected FIFO writes are queued at stimulus time.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
`ifdef UART_TX_ARB_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic                    clk;
  logic                    rst_n;
  logic                    enable;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*8-1:0]    req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    full;
  logic                    wr_en;
  logic [7:0]              data_in;
  logic                    tx_enable;
  logic [NUM_REQ-1:0]      grant;
  logic                    busy;

  uart_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .FIFO_WIDTH    (8),
    .MAX_BURST     (16),
    .STALL_TIMEOUT (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .full      (full),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .tx_enable (tx_enable),
    .grant     (grant),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    int         gi;
    bit         hdr;
  } exp_t;

  exp_t               expq[$];
  logic [8:0]         rq[NUM_REQ][$];
  logic [NUM_REQ-1:0] hold;
  logic [NUM_REQ-1:0] acc;
  int                 cycle;
  int                 log_cyc[$];
  logic [7:0]         log_data[$];
  logic [NUM_REQ-1:0] log_grant[$];
  int                 checks;
  int                 errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard on every FIFO write, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      acc = req_valid & req_ready;
      if (wr_en) begin
        log_cyc.push_back(cycle);
        log_data.push_back(data_in);
        log_grant.push_back(grant);
        if (expq.size() == 0) begin
          check("unexpected_write", {24'h0, data_in}, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          check("wr_data", {24'h0, data_in}, {24'h0, e.data});
          check("wr_grant", {28'h0, grant}, 32'(1 << e.gi));
          check("wr_ready", {28'h0, req_ready}, e.hdr ? 32'h0 : 32'(1 << e.gi));
        end
      end
    end
  end

  // Requester models: present queue heads, retire bytes accepted last cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      acc = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq[i].size() > 0 && !hold[i]) begin
          req_valid[i]         = 1'b1;
          req_data[i*8 +: 8]   = rq[i][0][7:0];
          req_last[i]          = rq[i][0][8];
        end else begin
          req_valid[i]         = 1'b0;
          req_data[i*8 +: 8]   = 8'h00;
          req_last[i]          = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_header(input int gi);
    exp_t e;
    if (HDR != 0) begin
      e.data = 8'h80 | 8'(gi);
      e.gi   = gi;
      e.hdr  = 1'b1;
      expq.push_back(e);
    end
  endtask

  task automatic applyStimulus(input int gi, input logic [7:0] d, input logic last);
    exp_t e;
    rq[gi].push_back({last, d});
    e.data = d;
    e.gi   = gi;
    e.hdr  = 1'b0;
    expq.push_back(e);
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((expq.size() != 0 || pending() || busy) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(n < budget), 32'h1);
  endtask

  task automatic wait_writes(input string name, input int k, input int budget);
    int n = 0;
    while (log_cyc.size() < k && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(n < budget), 32'h1);
  endtask

  function automatic int find_cycle(input logic [7:0] d, input int gi);
    int r = -1;
    for (int k = 0; k < log_data.size(); k++) begin
      if (log_data[k] == d && log_grant[k] == NUM_REQ'(1 << gi)) r = log_cyc[k];
    end
    return r;
  endfunction

  task automatic clear_log();
    log_cyc.delete();
    log_data.delete();
    log_grant.delete();
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_grant"},     {28'h0, grant},     32'h0);
    check({tag, "_busy"},      {31'h0, busy},      32'h0);
    check({tag, "_wr_en"},     {31'h0, wr_en},     32'h0);
    check({tag, "_req_ready"}, {28'h0, req_ready}, 32'h0);
    check({tag, "_data_in"},   {24'h0, data_in},   32'h0);
    check({tag, "_tx_enable"}, {31'h0, tx_enable}, 32'h0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cycle     = 0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    full      = 1'b0;
    hold      = '0;
    acc       = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    #3;
    checkOutput("reset");
    step();
    step();
    rst_n = 1'b1;

    $display("[TB] reset priority and enable gating");
    exp_header(0);
    applyStimulus(0, 8'h11, 1'b1);
    exp_header(2);
    applyStimulus(2, 8'h33, 1'b1);
    repeat (3) step();
    check("disabled_grant", {28'h0, grant}, 32'h0);
    check("disabled_busy", {31'h0, busy}, 32'h0);
    enable = 1'b1;
    step();
    check("tx_enable_on", {31'h0, tx_enable}, 32'h1);
    check("first_grant", {28'h0, grant}, 32'h1);
    drain("drain_prio", 200);
    check("prio_gap", 32'(find_cycle(8'h33, 2) - find_cycle(8'h11, 0)), 32'(2 + HDR));

    $display("[TB] max burst");
    clear_log();
    exp_header(1);
    for (int k = 0; k < 16; k++) applyStimulus(1, 8'(k), 1'b0);
    exp_header(1);
    for (int k = 16; k < 20; k++) applyStimulus(1, 8'(k), 1'b0);
    drain("drain_burst", 300);
    check("burst_gap", 32'(find_cycle(8'h10, 1) - find_cycle(8'h0F, 1)), 32'(2 + HDR));

    $display("[TB] back-pressure");
    clear_log();
    exp_header(2);
    for (int k = 0; k < 6; k++) applyStimulus(2, 8'h60 + 8'(k), k == 5);
    wait_writes("wait_bp", 2 + HDR, 50);
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_wr_en", {31'h0, wr_en}, 32'h0);
      check("bp_req_ready", {28'h0, req_ready}, 32'h0);
      check("bp_busy", {31'h0, busy}, 32'h1);
    end
    full = 1'b0;
    drain("drain_bp", 100);

    $display("[TB] stall timeout");
    clear_log();
    exp_header(3);
    applyStimulus(3, 8'hA0, 1'b0);
    wait_writes("wait_stall", 1 + HDR, 50);
    exp_header(0);
    applyStimulus(0, 8'hB0, 1'b1);
    drain("drain_stall", 200);
    check("stall_gap", 32'(find_cycle(8'hB0, 0) - find_cycle(8'hA0, 3)), 32'(66 + HDR));

    $display("[TB] reset mid-burst");
    clear_log();
    exp_header(1);
    for (int k = 0; k < 10; k++) applyStimulus(1, 8'hC0 + 8'(k), 1'b0);
    wait_writes("wait_midrst", 3 + HDR, 50);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst");
    expq.delete();
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    step();
    step();
    rst_n = 1'b1;
    exp_header(0);
    applyStimulus(0, 8'h44, 1'b1);
    exp_header(1);
    applyStimulus(1, 8'h55, 1'b1);
    drain("drain_postrst", 100);

`ifdef UART_TX_ARB_HDR_EN
    $display("[TB] header");
    clear_log();
    exp_header(2);
    applyStimulus(2, 8'h5A, 1'b1);
    drain("drain_hdr", 100);
    check("hdr_byte", {24'h0, log_data[0]}, 32'h82);
`endif

    check("scoreboard_empty", 32'(expq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the UART transmit FIFO write port among several byte-stream requesters. Grants one requester at a time for a burst, pushes its bytes into the TX FIFO under `full` back-pressure, and drives `tx_enable`. Sits between client logic and the UART wrapper's `wr_en` / `data_in` / `full` / `tx_enable` ports, in the `clk` domain.

## Interface

- `NUM_REQ`, 4: number of requesters, 2..16.
- `FIFO_WIDTH`, 8: byte width, matching the TX FIFO width.
- `MAX_BURST`, 16: maximum bytes per grant, ≥2.
- `STALL_TIMEOUT`, 64: consecutive cycles with granted `req_valid` low before the burst is abandoned, ≥1.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  allows new grants. Low lets the current burst finish, then holds in IDLE.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  NUM_REQ*FIFO_WIDTH  requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- `req_last`  in  NUM_REQ  marks the final byte of a requester's message.
- `req_ready`  out  NUM_REQ  byte accepted when `req_valid[i] && req_ready[i]`.
- `full`  in  1  TX FIFO full.
- `wr_en`  out  1  TX FIFO write strobe.
- `data_in`  out  FIFO_WIDTH  TX FIFO write data.
- `tx_enable`  out  1  transmitter enable.
- `grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `busy`  out  1  a burst is in progress (state ≠ IDLE).

## Operation

- **States:** IDLE, HDR (only with the macro), XFER.
- **IDLE:**
  - If `enable` is high and any `req_valid` is high, select the first requester searching from `last_grant+1` modulo NUM_REQ.
  - Register `grant`, clear the burst and stall counters, and go to HDR or XFER.
  - The request vector is sampled in IDLE only. Later `req_valid` changes do not alter the winner.
- **XFER:**
  - `wr_en = req_valid[g] && !full`, combinational.
  - `req_ready[g] = wr_en`. `req_ready` of non-granted requesters is 0.
  - `data_in = req_data[g]`.
  - Each write increments the burst counter.
  - The burst ends after the write where `req_last[g]` is high, or after the `MAX_BURST`-th write. It then returns to IDLE, and `last_grant = g`.
- **Stall timeout:**
  - The stall counter increments on cycles with `req_valid[g]` low, and resets on any cycle where it is high.
  - When it reaches `STALL_TIMEOUT`, go to IDLE with no write.
  - `full` high with `req_valid` high is back-pressure, not a stall: hold and do not count.
- **Simultaneous events:** when `req_last` and the `MAX_BURST`-th byte coincide, there is a single burst end.
- **tx_enable:** registered copy of `enable` (1-cycle delay). Independent of FSM state.
- **Counter widths:** burst counter is `$clog2(MAX_BURST+1)` bits; stall counter is `$clog2(STALL_TIMEOUT+1)` bits; neither wraps.
- **Reset:**
  - Asynchronous reset at any point, including mid-burst, returns to IDLE.
  - Reset values: `grant=0`, `busy=0`, `wr_en=0`, `req_ready=0`, `data_in=0`, `tx_enable=0`, counters 0.
  - `last_grant=NUM_REQ-1`, so requester 0 has first priority.
  - A partially sent message is not resumed.

## Timing

- Arbitration latency: one cycle. `req_valid` high in IDLE at edge N gives `grant` valid after N; the first write can occur in cycle N+1.
- Back-to-back bursts are separated by exactly one IDLE cycle. Peak throughput is MAX_BURST bytes per MAX_BURST+1 cycles, or +2 cycles with the header.
- Write and handshake are in the same cycle; there is no pipeline stage between requester and FIFO.
- `full` affects `wr_en` combinationally in the same cycle.

## Configuration

- Macro: `UART_TX_ARB_HDR_EN`.
- **Defined:**
  - After a grant, the HDR state writes one header byte `{1'b1, 0…, grant_index}` (MSB set, index in the low `$clog2(NUM_REQ)` bits) when `!full`, then moves to XFER.
  - `req_ready` is 0 during HDR.
  - The header does not count toward MAX_BURST.
  - A timeout cannot occur in HDR.
- **Undefined:** HDR does not exist; IDLE goes directly to XFER.

## Structure

- Shared package `uart_tx_arb_pkg`:
  - State enum (IDLE/HDR/XFER).
  - Header MSB marker constant.
  - Index-width function.
- Sub-module `uart_rr_picker`: combinational round-robin selector taking request vector and `last_grant`, returning one-hot and index. This is the natural split; everything else stays in one module.

## Test plan

- **Reset priority:** reset; requesters 0 and 2 valid, single-byte `req_last` each. Expect FIFO writes 0x11 (req0) then 0x33 (req2), `grant` 0001→0→0100.
- **Max burst:** req1 streams 20 bytes 0x00..0x13 with no `req_last`, MAX_BURST=16. Expect the burst to end after 0x0F, one IDLE cycle, re-grant req1, then 0x10..0x13.
- **Back-pressure:** `full` held high for 5 cycles mid-burst. Expect `wr_en=0` and `req_ready=0` for 5 cycles, no byte lost or duplicated, no timeout.
- **Stall timeout:** granted req3 drops `req_valid` for 64 cycles with STALL_TIMEOUT=64. Expect return to IDLE and req0 (waiting) granted next.
- **Reset mid-burst:** `rst_n` low mid-burst. Expect all outputs at reset values immediately (asynchronous); after release, req0 wins.
- **Header (with `UART_TX_ARB_HDR_EN`):** req2 sends 0x5A with last. Expect FIFO sequence 0x82, 0x5A; `req_ready` low during the header cycle.
